// File: rtl/lcd_seq_ctrl.sv
`default_nettype none
// ============================================================================
// lcd_seq_ctrl : LCD power-up/init command sequencer and rectangular fill
//                streamer. Define LCD_SEQ_IDLE_GAP_EN for an idle cycle
//                after every word issued.
// Revision     : 1.0
// ============================================================================
module lcd_seq_ctrl #(
   parameter int unsigned PWR_DLY_CYC    = 1000,
   parameter int unsigned SWRST_DLY_CYC  = 500000,
   parameter int unsigned SLPOUT_DLY_CYC = 6000000,
   parameter logic [7:0]  MADCTL_VAL     = 8'h48,
   parameter int unsigned CNT_W          = 32
) (
   input  logic        clk,
   input  logic        reset,
   output logic [1:0]  lcd_ctrl,
   output logic [15:0] data,
   output logic        init_done,
   output logic        busy,
   input  logic        fill_req,
   input  logic [15:0] fill_x0,
   input  logic [15:0] fill_x1,
   input  logic [15:0] fill_y0,
   input  logic [15:0] fill_y1,
   input  logic [15:0] pix_data,
   input  logic        pix_valid,
   output logic        pix_ready,
   output logic        fill_done,
   output logic        fill_err
);

   localparam logic [2:0] S_PWR   = 3'd0;
   localparam logic [2:0] S_INIT  = 3'd1;
   localparam logic [2:0] S_IDLE  = 3'd2;
   localparam logic [2:0] S_CASET = 3'd3;
   localparam logic [2:0] S_PASET = 3'd4;
   localparam logic [2:0] S_RAMWR = 3'd5;
   localparam logic [2:0] S_PIX   = 3'd6;

   localparam logic [1:0] K_IDLE = 2'b00;
   localparam logic [1:0] K_CMD  = 2'b01;
   localparam logic [1:0] K_DATA = 2'b10;

   localparam logic [3:0]       c_ROM_LAST = 4'd8;
   localparam logic [CNT_W-1:0] c_ONE      = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] c_PWR_N    = CNT_W'(PWR_DLY_CYC);
   localparam logic [CNT_W-1:0] c_SWRST_N  = CNT_W'(SWRST_DLY_CYC);
   localparam logic [CNT_W-1:0] c_SLPOUT_N = CNT_W'(SLPOUT_DLY_CYC);

`ifdef LCD_SEQ_IDLE_GAP_EN
   localparam logic c_GAP_EN = 1'b1;
`else
   localparam logic c_GAP_EN = 1'b0;
`endif

   logic [2:0]       state_q, state_d;
   logic [3:0]       idx_q, idx_d;
   logic [2:0]       step_q, step_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] pix_cnt_q, pix_cnt_d;
   logic [15:0]      x0_q, x0_d, x1_q, x1_d, y0_q, y0_d, y1_q, y1_d;
   logic [1:0]       ctrl_q, ctrl_d;
   logic [15:0]      data_q, data_d;
   logic             init_done_q, init_done_d;
   logic             busy_q, busy_d;
   logic             fill_done_q, fill_done_d;
   logic             fill_err_q, fill_err_d;
   logic             gap_q, gap_d;

   logic [1:0]       w_rom_kind;
   logic [7:0]       w_rom_byte;
   logic [CNT_W-1:0] w_rom_wait;
   logic [1:0]       w_win_kind;
   logic [15:0]      w_win_data;
   logic [15:0]      w_lo, w_hi;
   logic [16:0]      w_span_x, w_span_y;
   logic [33:0]      w_area;
   logic             w_pix_ready;

   // Init ROM: kind K_IDLE marks a wait entry whose length is w_rom_wait.
   always_comb begin
      w_rom_kind = K_IDLE;
      w_rom_byte = 8'h00;
      w_rom_wait = c_ONE;
      case (idx_q)
         4'd0: begin w_rom_kind = K_CMD;  w_rom_byte = 8'h01;      end
         4'd1: w_rom_wait = c_SWRST_N;
         4'd2: begin w_rom_kind = K_CMD;  w_rom_byte = 8'h11;      end
         4'd3: w_rom_wait = c_SLPOUT_N;
         4'd4: begin w_rom_kind = K_CMD;  w_rom_byte = 8'h3A;      end
         4'd5: begin w_rom_kind = K_DATA; w_rom_byte = 8'h55;      end
         4'd6: begin w_rom_kind = K_CMD;  w_rom_byte = 8'h36;      end
         4'd7: begin w_rom_kind = K_DATA; w_rom_byte = MADCTL_VAL; end
         4'd8: begin w_rom_kind = K_CMD;  w_rom_byte = 8'h29;      end
         default: ;
      endcase
   end

   always_comb begin
      w_lo       = (state_q == S_PASET) ? y0_q : x0_q;
      w_hi       = (state_q == S_PASET) ? y1_q : x1_q;
      w_win_kind = K_DATA;
      w_win_data = 16'h0000;
      case (step_q)
         3'd0: begin
            w_win_kind = K_CMD;
            w_win_data = (state_q == S_PASET) ? 16'h002B : 16'h002A;
         end
         3'd1: w_win_data = {8'h00, w_lo[15:8]};
         3'd2: w_win_data = {8'h00, w_lo[7:0]};
         3'd3: w_win_data = {8'h00, w_hi[15:8]};
         3'd4: w_win_data = {8'h00, w_hi[7:0]};
         default: ;
      endcase
   end

   assign w_span_x    = {1'b0, fill_x1} - {1'b0, fill_x0} + 17'd1;
   assign w_span_y    = {1'b0, fill_y1} - {1'b0, fill_y0} + 17'd1;
   assign w_area      = {17'd0, w_span_x} * {17'd0, w_span_y};
   assign w_pix_ready = (state_q == S_PIX) && (pix_cnt_q != '0) && !gap_q;

   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      step_d      = step_q;
      cnt_d       = cnt_q;
      pix_cnt_d   = pix_cnt_q;
      x0_d        = x0_q;
      x1_d        = x1_q;
      y0_d        = y0_q;
      y1_d        = y1_q;
      ctrl_d      = K_IDLE;
      data_d      = 16'h0000;
      init_done_d = init_done_q;
      busy_d      = busy_q;
      fill_done_d = 1'b0;
      fill_err_d  = 1'b0;
      case (state_q)
         S_PWR: begin
            if (cnt_q + c_ONE >= c_PWR_N) begin
               state_d = S_INIT;
               cnt_d   = '0;
               idx_d   = 4'd0;
            end else begin
               cnt_d = cnt_q + c_ONE;
            end
         end
         S_INIT: begin
            if (w_rom_kind == K_IDLE) begin
               if (cnt_q + c_ONE >= w_rom_wait) begin
                  cnt_d = '0;
                  idx_d = idx_q + 4'd1;
               end else begin
                  cnt_d = cnt_q + c_ONE;
               end
            end else if (!gap_q) begin
               ctrl_d = w_rom_kind;
               data_d = {8'h00, w_rom_byte};
               if (idx_q == c_ROM_LAST) begin
                  init_done_d = 1'b1;
                  busy_d      = 1'b0;
                  state_d     = S_IDLE;
               end else begin
                  idx_d = idx_q + 4'd1;
               end
            end
         end
         S_IDLE: begin
            if (fill_req) begin
               if ((fill_x1 < fill_x0) || (fill_y1 < fill_y0)) begin
                  fill_err_d = 1'b1;
               end else begin
                  x0_d      = fill_x0;
                  x1_d      = fill_x1;
                  y0_d      = fill_y0;
                  y1_d      = fill_y1;
                  pix_cnt_d = CNT_W'(w_area);
                  busy_d    = 1'b1;
                  step_d    = 3'd0;
                  state_d   = S_CASET;
               end
            end
         end
         S_CASET, S_PASET: begin
            if (!gap_q) begin
               ctrl_d = w_win_kind;
               data_d = w_win_data;
               if (step_q == 3'd4) begin
                  step_d  = 3'd0;
                  state_d = (state_q == S_CASET) ? S_PASET : S_RAMWR;
               end else begin
                  step_d = step_q + 3'd1;
               end
            end
         end
         S_RAMWR: begin
            if (!gap_q) begin
               ctrl_d  = K_CMD;
               data_d  = 16'h002C;
               state_d = S_PIX;
            end
         end
         S_PIX: begin
            // A window whose area truncates to zero has nothing to stream.
            if (pix_cnt_q == '0) begin
               fill_done_d = 1'b1;
               busy_d      = 1'b0;
               state_d     = S_IDLE;
            end else if (pix_valid && w_pix_ready) begin
               ctrl_d    = K_DATA;
               data_d    = pix_data;
               pix_cnt_d = pix_cnt_q - c_ONE;
               if (pix_cnt_q == c_ONE) begin
                  fill_done_d = 1'b1;
                  busy_d      = 1'b0;
                  state_d     = S_IDLE;
               end
            end
         end
         default: state_d = S_PWR;
      endcase
      gap_d = c_GAP_EN && (ctrl_d != K_IDLE);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= S_PWR;
         idx_q       <= 4'd0;
         step_q      <= 3'd0;
         cnt_q       <= '0;
         pix_cnt_q   <= '0;
         x0_q        <= 16'h0000;
         x1_q        <= 16'h0000;
         y0_q        <= 16'h0000;
         y1_q        <= 16'h0000;
         ctrl_q      <= K_IDLE;
         data_q      <= 16'h0000;
         init_done_q <= 1'b0;
         busy_q      <= 1'b1;
         fill_done_q <= 1'b0;
         fill_err_q  <= 1'b0;
         gap_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         step_q      <= step_d;
         cnt_q       <= cnt_d;
         pix_cnt_q   <= pix_cnt_d;
         x0_q        <= x0_d;
         x1_q        <= x1_d;
         y0_q        <= y0_d;
         y1_q        <= y1_d;
         ctrl_q      <= ctrl_d;
         data_q      <= data_d;
         init_done_q <= init_done_d;
         busy_q      <= busy_d;
         fill_done_q <= fill_done_d;
         fill_err_q  <= fill_err_d;
         gap_q       <= gap_d;
      end
   end

   assign lcd_ctrl  = ctrl_q;
   assign data      = data_q;
   assign init_done = init_done_q;
   assign busy      = busy_q;
   assign pix_ready = w_pix_ready;
   assign fill_done = fill_done_q;
   assign fill_err  = fill_err_q;

endmodule
`default_nettype wire

// File: tb/tb_lcd_seq_ctrl.sv
`default_nettype none
// tb_lcd_seq_ctrl : scripted + randomized bench with a word-queue reference model.
module tb_lcd_seq_ctrl;

   localparam int PWR    = 4;
   localparam int SWRST  = 3;
   localparam int SLPOUT = 5;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [1:0]  lcd_ctrl;
   logic [15:0] data;
   logic        init_done, busy, pix_ready, fill_done, fill_err;
   logic        fill_req = 1'b0;
   logic [15:0] fill_x0 = '0, fill_x1 = '0, fill_y0 = '0, fill_y1 = '0;
   logic [15:0] pix_data = '0;
   logic        pix_valid = 1'b0;

   int n_checks = 0;
   int n_fail   = 0;

   lcd_seq_ctrl #(
      .PWR_DLY_CYC(PWR), .SWRST_DLY_CYC(SWRST), .SLPOUT_DLY_CYC(SLPOUT),
      .MADCTL_VAL(8'h48), .CNT_W(32)
   ) dut (
      .clk(clk), .reset(reset), .lcd_ctrl(lcd_ctrl), .data(data),
      .init_done(init_done), .busy(busy), .fill_req(fill_req),
      .fill_x0(fill_x0), .fill_x1(fill_x1), .fill_y0(fill_y0), .fill_y1(fill_y1),
      .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(pix_ready),
      .fill_done(fill_done), .fill_err(fill_err)
   );

   always #5 clk = ~clk;

   function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endfunction

   // Reference model: every cycle either replays one scripted word/idle
   // entry, streams one pixel, or considers a new fill request.
   logic [17:0] script [$];
   bit          m_init_done, m_busy, m_pix;
   int          m_rem;
   logic [1:0]  e_ctrl;
   logic [15:0] e_data;
   bit          e_done, e_err;

   function automatic void push_word(input logic [1:0] k, input logic [15:0] d);
      script.push_back({k, d});
   endfunction

   function automatic void push_idle(input int n);
      for (int i = 0; i < n; i++) script.push_back(18'h0);
   endfunction

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         script.delete();
         push_idle(PWR);
         push_word(2'b01, 16'h01); push_idle(SWRST);
         push_word(2'b01, 16'h11); push_idle(SLPOUT);
         push_word(2'b01, 16'h3A); push_word(2'b10, 16'h55);
         push_word(2'b01, 16'h36); push_word(2'b10, 16'h48);
         push_word(2'b01, 16'h29);
         m_init_done = 0; m_busy = 1; m_pix = 0; m_rem = 0;
         e_ctrl = 0; e_data = 0; e_done = 0; e_err = 0;
      end else begin
         e_ctrl = 0; e_data = 0; e_done = 0; e_err = 0;
         if (m_pix) begin
            if (pix_valid && m_rem != 0) begin
               e_ctrl = 2'b10; e_data = pix_data; m_rem--;
               if (m_rem == 0) begin e_done = 1; m_busy = 0; m_pix = 0; end
            end
         end else if (script.size() != 0) begin
            {e_ctrl, e_data} = script.pop_front();
            if (script.size() == 0) begin
               if (!m_init_done) begin m_init_done = 1; m_busy = 0; end
               else m_pix = 1;
            end
         end else if (m_init_done && !m_busy && fill_req) begin
            if (fill_x1 < fill_x0 || fill_y1 < fill_y0) e_err = 1;
            else begin
               m_busy = 1;
               m_rem  = (int'(fill_x1) - int'(fill_x0) + 1) * (int'(fill_y1) - int'(fill_y0) + 1);
               push_word(2'b01, 16'h2A);
               push_word(2'b10, {8'h0, fill_x0[15:8]}); push_word(2'b10, {8'h0, fill_x0[7:0]});
               push_word(2'b10, {8'h0, fill_x1[15:8]}); push_word(2'b10, {8'h0, fill_x1[7:0]});
               push_word(2'b01, 16'h2B);
               push_word(2'b10, {8'h0, fill_y0[15:8]}); push_word(2'b10, {8'h0, fill_y0[7:0]});
               push_word(2'b10, {8'h0, fill_y1[15:8]}); push_word(2'b10, {8'h0, fill_y1[7:0]});
               push_word(2'b01, 16'h2C);
            end
         end
      end
   end

   always @(negedge clk) begin
      check("lcd_ctrl",  32'(lcd_ctrl),  32'(e_ctrl));
      check("data",      32'(data),      32'(e_data));
      check("init_done", 32'(init_done), 32'(m_init_done));
      check("busy",      32'(busy),      32'(m_busy));
      check("pix_ready", 32'(pix_ready), 32'(m_pix && m_rem != 0));
      check("fill_done", 32'(fill_done), 32'(e_done));
      check("fill_err",  32'(fill_err),  32'(e_err));
   end

   // Directed-scenario observation state
   logic [17:0] log_q [$];
   logic [1:0]  pctl_q [$];
   int          rdy_cnt, done_at, err_seen;
   logic [15:0] pix_lit [4] = '{16'hF800, 16'h07E0, 16'h001F, 16'hFFFF};
   logic [17:0] fill_lit [15] = '{18'h1002A, 18'h20000, 18'h20002, 18'h20000, 18'h20003,
                                  18'h1002B, 18'h20001, 18'h20004, 18'h20001, 18'h20005,
                                  18'h1002C, 18'h2F800, 18'h207E0, 18'h2001F, 18'h2FFFF};

   task automatic init_trace();
      int          at  [7] = '{5, 9, 15, 16, 17, 18, 19};
      logic [17:0] lit [7] = '{18'h10001, 18'h10011, 18'h1003A, 18'h20055,
                               18'h10036, 18'h20048, 18'h10029};
      int k = 0;
      for (int c = 1; c <= 19; c++) begin
         @(negedge clk);
         if (c == 4 || c == 8 || c == 14) check("init_idle", 32'(lcd_ctrl), 32'd0);
         if (c == at[k]) begin
            check("init_word", 32'({lcd_ctrl, data}), 32'(lit[k]));
            if (k < 6) k++;
         end
         if (c == 18) check("init_done_early", 32'(init_done), 32'd0);
         if (c == 19) begin
            check("init_done_set", 32'(init_done), 32'd1);
            check("init_busy_clr", 32'(busy), 32'd0);
         end
      end
   endtask

   task automatic req_fill(input logic [15:0] x0, x1, y0, y1);
      fill_x0 = x0; fill_x1 = x1; fill_y0 = y0; fill_y1 = y1;
      fill_req = 1'b1;
      @(negedge clk);
      fill_req = 1'b0;
   endtask

   task automatic stream(input int ncyc, input bit stall, input int stop_at);
      bit vpat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
      int i = 0;
      int p = 0;
      log_q.delete(); pctl_q.delete();
      rdy_cnt = 0; done_at = 0; err_seen = 0;
      for (int c = 0; c < ncyc; c++) begin
         @(negedge clk);
         if (lcd_ctrl != 2'b00) log_q.push_back({lcd_ctrl, data});
         if (fill_done) done_at = log_q.size();
         if (fill_err) err_seen++;
         if (p >= 1 && pctl_q.size() < p) pctl_q.push_back(lcd_ctrl);
         if (stop_at != 0 && log_q.size() == stop_at) break;
         fill_req = stall && (c == 2);
         if (c == 2) begin fill_x0 = 16'd9; fill_x1 = 16'd1; end
         if (pix_ready) begin
            rdy_cnt++;
            pix_valid = stall ? (p < 6 ? vpat[p] : 1'b0) : 1'b1;
            pix_data  = pix_lit[i];
            if (pix_valid && i < 3) i++;
            p++;
         end else begin
            pix_valid = 1'b0;
         end
      end
      pix_valid = 1'b0;
      fill_req  = 1'b0;
   endtask

   initial begin
      #2 reset = 1'b1;
      #1;
      check("rst_ctrl", 32'(lcd_ctrl), 32'd0);
      check("rst_busy", 32'(busy), 32'd1);
      check("rst_init_done", 32'(init_done), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      init_trace();

      // 2x2 fill, pix_valid held high
      req_fill(16'd2, 16'd3, 16'h0104, 16'h0105);
      stream(22, 1'b0, 0);
      check("fill_len", 32'(log_q.size()), 32'd15);
      for (int k = 0; k < 15; k++)
         if (k < log_q.size()) check("fill_word", 32'(log_q[k]), 32'(fill_lit[k]));
      check("fill_done_pos", 32'(done_at), 32'd15);
      check("ready_cycles", 32'(rdy_cnt), 32'd4);

      // Same fill with stalls and an ignored request mid-fill
      req_fill(16'd2, 16'd3, 16'h0104, 16'h0105);
      stream(26, 1'b1, 0);
      begin
         logic [1:0] plit [6] = '{2'b10, 2'b00, 2'b00, 2'b10, 2'b10, 2'b10};
         check("stall_len", 32'(pctl_q.size()), 32'd6);
         for (int k = 0; k < 6; k++)
            if (k < pctl_q.size()) check("stall_ctrl", 32'(pctl_q[k]), 32'(plit[k]));
      end
      for (int k = 11; k < 15; k++)
         if (k < log_q.size()) check("stall_pix", 32'(log_q[k]), 32'(fill_lit[k]));
      check("stall_done_pos", 32'(done_at), 32'd15);
      check("busy_req_no_err", 32'(err_seen), 32'd0);

      // Rejected window
      req_fill(16'd5, 16'd4, 16'd0, 16'd0);
      check("err_pulse", 32'(fill_err), 32'd1);
      check("err_busy", 32'(busy), 32'd0);
      @(negedge clk);
      check("err_once", 32'(fill_err), 32'd0);
      check("err_no_word", 32'(lcd_ctrl), 32'd0);

      // Single-pixel window
      req_fill(16'd7, 16'd7, 16'd9, 16'd9);
      stream(16, 1'b0, 0);
      check("one_pix_len", 32'(log_q.size()), 32'd12);
      check("one_pix_done", 32'(done_at), 32'd12);

      // Reset after the 2nd pixel word
      req_fill(16'd2, 16'd3, 16'h0104, 16'h0105);
      stream(30, 1'b0, 13);
      check("pre_rst_words", 32'(log_q.size()), 32'd13);
      #2 reset = 1'b1;
      #1;
      check("midrst_vals", 32'({lcd_ctrl, data, init_done, busy, pix_ready, fill_done, fill_err}),
            32'({2'b00, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0}));
      @(negedge clk);
      reset = 1'b0;
      init_trace();

      // Randomized fills
      for (int f = 0; f < 40; f++) begin
         logic [15:0] x0, y0;
         int bound;
         x0 = 16'($urandom_range(1, 400));
         y0 = 16'($urandom_range(1, 400));
         fill_x0 = x0; fill_y0 = y0;
         fill_x1 = x0 + 16'($urandom_range(0, 3));
         fill_y1 = y0 + 16'($urandom_range(0, 3));
         if ($urandom_range(0, 5) == 0) fill_x1 = x0 - 16'd1;
         if ($urandom_range(0, 7) == 0) fill_y1 = y0 - 16'd1;
         for (int g = $urandom_range(0, 3); g > 0; g--) begin
            pix_valid = 1'($urandom); pix_data = 16'($urandom);
            @(negedge clk);
         end
         fill_req = 1'b1;
         @(negedge clk);
         fill_req = 1'b0;
         bound = 0;
         while (m_busy && bound < 200) begin
            pix_valid = ($urandom_range(0, 2) != 0);
            pix_data  = 16'($urandom);
            fill_req  = ($urandom_range(0, 9) == 0);
            fill_x0   = 16'($urandom); fill_x1 = 16'($urandom);
            @(negedge clk);
            bound++;
         end
         fill_req = 1'b0;
         pix_valid = 1'b0;
         check("fill_timeout", 32'(m_busy), 32'd0);
      end

      repeat (3) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
